// File: rtl/serial_cmd_ctrl_pkg.sv
// Shared command codes, response constants and FSM encodings for the
// serial host-command front end.
package serial_cmd_pkg;

   localparam logic [7:0] CMD_ADDR     = 8'h01;
   localparam logic [7:0] CMD_LOAD     = 8'h02;
   localparam logic [7:0] CMD_WRITE    = 8'h03;
   localparam logic [7:0] CMD_READ     = 8'h04;
   localparam logic [7:0] CMD_READ_REQ = 8'h05;
   localparam logic [7:0] CMD_COUNT    = 8'h06;
   localparam logic [7:0] CMD_CONST    = 8'h07;

   localparam logic [31:0] RESP_ERR       = 32'hFFFF_FFFF;
   localparam logic [31:0] RESP_WRITE_ACK = 32'd3;

   localparam int FRAME_BYTES = 5;
   localparam int RESP_BYTES  = 4;

   typedef enum logic [2:0] {
      ST_RX        = 3'd0,
      ST_EXEC      = 3'd1,
      ST_RAM_ISSUE = 3'd2,
      ST_RAM_WAIT  = 3'd3,
      ST_TX_RESP   = 3'd4
   } ctrl_state_e;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_BUSY = 2'd2
   } tx_state_e;

endpackage

// File: rtl/serial_cmd_ctrl_if.sv
// UART and SRAM-request signal bundle of the command front end; master is
// the controller side, slave is the UART/driver side.
interface serial_cmd_ctrl_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
);
   logic              rcv;
   logic [7:0]        rxdata;
   logic              tx_ready;
   logic              tx_start;
   logic [7:0]        txdata;
   logic              ram_ready;
   logic [DATA_W-1:0] ram_data_read;
   logic              ram_start;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_data_write;
   logic              busy;
   logic              overrun;

   modport master (
      input  rcv, rxdata, tx_ready, ram_ready, ram_data_read,
      output tx_start, txdata, ram_start, ram_re, ram_address,
             ram_data_write, busy, overrun
   );

   modport slave (
      output rcv, rxdata, tx_ready, ram_ready, ram_data_read,
      input  tx_start, txdata, ram_start, ram_re, ram_address,
             ram_data_write, busy, overrun
   );
endinterface

// File: rtl/serial_cmd_ctrl_resp_serializer.sv
// Sends a 32-bit response as four bytes, MSB first, through the uart_tx
// start/ready handshake; done pulses as the last byte is taken.
module resp_serializer
   import serial_cmd_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        load,
   input  logic [31:0] data,
   input  logic        tx_ready,
   output logic        tx_start,
   output logic [7:0]  txdata,
   output logic        done
);
   tx_state_e   state_r, state_n;
   logic [31:0] shift_r, shift_n;
   logic [2:0]  left_r, left_n;
   logic        tx_start_r, tx_start_n;
   logic [7:0]  txdata_r, txdata_n;
   logic        done_s;

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r    <= TX_IDLE;
         shift_r    <= 32'd0;
         left_r     <= 3'd0;
         tx_start_r <= 1'b0;
         txdata_r   <= 8'd0;
      end else begin
         state_r    <= state_n;
         shift_r    <= shift_n;
         left_r     <= left_n;
         tx_start_r <= tx_start_n;
         txdata_r   <= txdata_n;
      end
   end

   // Next-state logic; a load with tx_ready already high starts the first byte at once
   always_comb begin
      state_n    = state_r;
      shift_n    = shift_r;
      left_n     = left_r;
      tx_start_n = 1'b0;
      txdata_n   = txdata_r;
      done_s     = 1'b0;
      case (state_r)
         TX_IDLE: begin
            if (load) begin
               shift_n = data;
               left_n  = 3'(RESP_BYTES);
               if (tx_ready) begin
                  tx_start_n = 1'b1;
                  txdata_n   = data[31:24];
                  state_n    = TX_BUSY;
               end else begin
                  state_n = TX_SEND;
               end
            end else begin
               state_n = TX_IDLE;
            end
         end
         TX_SEND: begin
            if (tx_ready) begin
               tx_start_n = 1'b1;
               txdata_n   = shift_r[31:24];
               state_n    = TX_BUSY;
            end else begin
               state_n = TX_SEND;
            end
         end
         TX_BUSY: begin
            // tx_ready is still high while our strobe is in flight
            if (!tx_ready && !tx_start_r) begin
               shift_n = {shift_r[23:0], 8'd0};
               left_n  = left_r - 3'd1;
               if (left_r == 3'd1) begin
                  done_s  = 1'b1;
                  state_n = TX_IDLE;
               end else begin
                  state_n = TX_SEND;
               end
            end else begin
               state_n = TX_BUSY;
            end
         end
         default: begin
            state_n = TX_IDLE;
         end
      endcase
   end

   assign tx_start = tx_start_r;
   assign txdata   = txdata_r;
   assign done     = done_s;

endmodule

// File: rtl/serial_cmd_ctrl.sv
// Host-command front end: assembles 5-byte UART frames, executes them against
// the SRAM driver and returns a 4-byte big-endian response.
module serial_cmd_ctrl
   import serial_cmd_pkg::*;
#(
   parameter int ADDR_W         = 13,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 1200000,
   parameter int CONST_VAL      = 259
) (
   input logic               clk,
   input logic               rstn,
   serial_cmd_ctrl_if.master bus
);
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

   ctrl_state_e       state_r, state_n;
   logic [39:0]       frame_r, frame_n;
   logic [2:0]        byte_cnt_r, byte_cnt_n;
   logic [TIMER_W-1:0] timer_r, timer_n;
   logic [31:0]       count_r, count_n;
   logic [31:0]       resp_r, resp_n;
   logic [ADDR_W-1:0] ram_address_r, ram_address_n;
   logic [DATA_W-1:0] ram_data_write_r, ram_data_write_n;
   logic              ram_re_r, ram_re_n;
   logic              ram_start_r, ram_start_n;
   logic              first_r, first_n;
   logic              busy_r, busy_n;
   logic              overrun_r, overrun_n;

   logic [7:0]        cmd_s;
   logic [31:0]       op_s;
   logic              load_s;
   logic [31:0]       load_data_s;
   logic              ser_done_s;
   logic              ser_tx_start_s;
   logic [7:0]        ser_txdata_s;

   function automatic logic [31:0] zext_data(input logic [DATA_W-1:0] d);
      return 32'(d);
   endfunction

   assign cmd_s = frame_r[39:32];
   assign op_s  = frame_r[31:0];

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r          <= ST_RX;
         frame_r          <= 40'd0;
         byte_cnt_r       <= 3'd0;
         timer_r          <= {TIMER_W{1'b0}};
         count_r          <= 32'd0;
         resp_r           <= 32'd0;
         ram_address_r    <= {ADDR_W{1'b0}};
         ram_data_write_r <= {DATA_W{1'b0}};
         ram_re_r         <= 1'b0;
         ram_start_r      <= 1'b0;
         first_r          <= 1'b0;
         busy_r           <= 1'b0;
         overrun_r        <= 1'b0;
      end else begin
         state_r          <= state_n;
         frame_r          <= frame_n;
         byte_cnt_r       <= byte_cnt_n;
         timer_r          <= timer_n;
         count_r          <= count_n;
         resp_r           <= resp_n;
         ram_address_r    <= ram_address_n;
         ram_data_write_r <= ram_data_write_n;
         ram_re_r         <= ram_re_n;
         ram_start_r      <= ram_start_n;
         first_r          <= first_n;
         busy_r           <= busy_n;
         overrun_r        <= overrun_n;
      end
   end

   // Frame assembly, command execution and SRAM handshake
   always_comb begin
      state_n          = state_r;
      frame_n          = frame_r;
      byte_cnt_n       = byte_cnt_r;
      timer_n          = timer_r;
      count_n          = count_r;
      resp_n           = resp_r;
      ram_address_n    = ram_address_r;
      ram_data_write_n = ram_data_write_r;
      ram_re_n         = ram_re_r;
      ram_start_n      = 1'b0;
      first_n          = first_r;
      load_s           = 1'b0;
      load_data_s      = resp_r;
      overrun_n        = bus.rcv & (state_r != ST_RX);
      case (state_r)
         ST_RX: begin
            if (bus.rcv) begin
               frame_n = {frame_r[31:0], bus.rxdata};
               timer_n = {TIMER_W{1'b0}};
               if (byte_cnt_r == 3'(FRAME_BYTES - 1)) begin
                  byte_cnt_n = 3'd0;
                  state_n    = ST_EXEC;
               end else begin
                  byte_cnt_n = byte_cnt_r + 3'd1;
               end
            end else if (byte_cnt_r != 3'd0) begin
               // Inter-byte timeout drops the partial frame
               if (timer_r == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                  byte_cnt_n = 3'd0;
                  timer_n    = {TIMER_W{1'b0}};
               end else begin
                  timer_n = timer_r + TIMER_W'(1);
               end
            end else begin
               timer_n = {TIMER_W{1'b0}};
            end
         end
         ST_EXEC: begin
            case (cmd_s)
               CMD_ADDR: begin
                  ram_address_n = op_s[ADDR_W-1:0];
                  resp_n        = op_s;
               end
               CMD_LOAD: begin
                  ram_data_write_n = op_s[DATA_W-1:0];
                  resp_n           = op_s;
               end
               CMD_WRITE:    ram_re_n = 1'b0;
               CMD_READ:     resp_n   = zext_data(bus.ram_data_read);
               CMD_READ_REQ: ram_re_n = 1'b1;
               CMD_COUNT: begin
                  resp_n  = count_r;
                  count_n = count_r + 32'd1;
               end
               CMD_CONST:    resp_n = 32'(CONST_VAL);
               default:      resp_n = RESP_ERR;
            endcase
            if ((cmd_s == CMD_WRITE) || (cmd_s == CMD_READ_REQ)) begin
               state_n = ST_RAM_ISSUE;
            end else begin
               load_s      = 1'b1;
               load_data_s = resp_n;
               state_n     = ST_TX_RESP;
            end
         end
         ST_RAM_ISSUE: begin
            if (bus.ram_ready) begin
               ram_start_n = 1'b1;
               first_n     = 1'b1;
               state_n     = ST_RAM_WAIT;
            end else begin
               state_n = ST_RAM_ISSUE;
            end
         end
         ST_RAM_WAIT: begin
            // The driver drops ram_ready one cycle after seeing ram_start
            if (first_r) begin
               first_n = 1'b0;
            end else if (bus.ram_ready) begin
               resp_n      = ram_re_r ? zext_data(bus.ram_data_read) : RESP_WRITE_ACK;
               load_s      = 1'b1;
               load_data_s = resp_n;
               state_n     = ST_TX_RESP;
            end else begin
               state_n = ST_RAM_WAIT;
            end
         end
         ST_TX_RESP: begin
            if (ser_done_s) begin
               state_n = ST_RX;
            end else begin
               state_n = ST_TX_RESP;
            end
         end
         default: begin
            state_n = ST_RX;
         end
      endcase
      busy_n = (state_n != ST_RX);
   end

   resp_serializer u_resp_serializer (
      .clk      (clk),
      .rstn     (rstn),
      .load     (load_s),
      .data     (load_data_s),
      .tx_ready (bus.tx_ready),
      .tx_start (ser_tx_start_s),
      .txdata   (ser_txdata_s),
      .done     (ser_done_s)
   );

   assign bus.tx_start       = ser_tx_start_s;
   assign bus.txdata         = ser_txdata_s;
   assign bus.ram_start      = ram_start_r;
   assign bus.ram_re         = ram_re_r;
   assign bus.ram_address    = ram_address_r;
   assign bus.ram_data_write = ram_data_write_r;
   assign bus.busy           = busy_r;
   assign bus.overrun        = overrun_r;

endmodule

// File: tb/tb_serial_cmd_ctrl.sv
// Scoreboard bench for serial_cmd_ctrl: random frames against a command-level
// reference model, with UART and SRAM-driver models around the DUT.
module tb_serial_cmd_ctrl;
   import serial_cmd_pkg::*;

   typedef struct {
      logic        re;
      logic [12:0] addr;
      logic [7:0]  data;
   } ram_op_t;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   serial_cmd_ctrl_if #(.ADDR_W(13), .DATA_W(8)) sif ();

   serial_cmd_ctrl #(
      .ADDR_W(13), .DATA_W(8), .TIMEOUT_CYCLES(100), .CONST_VAL(259)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (sif)
   );

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   ram_op_t    ram_q[$];
   logic [7:0] ram_mem [0:8191];
   logic [7:0] ref_mem [0:8191];
   logic [12:0] m_addr;
   logic [7:0]  m_wdata;
   logic [7:0]  m_last_read;
   logic [31:0] m_count;
   int n_ram_start = 0;
   bit ram_hold  = 1'b0;
   bit ram_stall = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_idle(input string nm);
      check({nm, "_strobes"}, {27'd0, sif.tx_start, sif.ram_start, sif.ram_re, sif.busy, sif.overrun}, 32'd0);
      check({nm, "_data"}, {16'd0, sif.txdata, sif.ram_data_write}, 32'd0);
      check({nm, "_addr"}, {19'd0, sif.ram_address}, 32'd0);
   endtask

   // UART transmitter model: goes busy 0-1 cycles after a start strobe
   initial begin : uart_tx_model
      sif.tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (sif.tx_start === 1'b1) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            sif.tx_ready = 1'b0;
            repeat ($urandom_range(2, 6)) @(negedge clk);
            sif.tx_ready = 1'b1;
         end
      end
   end

   // Response monitor: every tx_start byte is popped against the scoreboard
   initial begin : tx_monitor
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (sif.tx_start === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_byte: got unexpected byte %h, expected none", sif.txdata);
            end else begin
               e = exp_q.pop_front();
               check("tx_byte", {24'd0, sif.txdata}, {24'd0, e});
            end
         end
      end
   end

   // SRAM driver model with request checking
   initial begin : ram_model
      ram_op_t got;
      ram_op_t exp_op;
      sif.ram_ready     = 1'b1;
      sif.ram_data_read = 8'h00;
      forever begin
         @(negedge clk);
         if (sif.ram_start === 1'b1) begin
            n_ram_start++;
            got.re   = sif.ram_re;
            got.addr = sif.ram_address;
            got.data = sif.ram_data_write;
            if (ram_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ram_req: got unexpected request re=%0b addr=%h, expected none", got.re, got.addr);
            end else begin
               exp_op = ram_q.pop_front();
               check("ram_re", {31'd0, got.re}, {31'd0, exp_op.re});
               check("ram_addr", {19'd0, got.addr}, {19'd0, exp_op.addr});
               if (!exp_op.re) check("ram_wdata", {24'd0, got.data}, {24'd0, exp_op.data});
            end
            sif.ram_ready = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            while (ram_stall) @(negedge clk);
            if (got.re) sif.ram_data_read = ram_mem[got.addr];
            else        ram_mem[got.addr] = got.data;
            sif.ram_ready = 1'b1;
         end else begin
            sif.ram_ready = ~ram_hold;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      sif.rcv    = 1'b1;
      sif.rxdata = b;
      @(negedge clk);
      sif.rcv    = 1'b0;
      sif.rxdata = 8'($urandom);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (sif.busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(nm, {31'd0, sif.busy}, 32'd0);
   endtask

   // Reference model of one command, then frame transmission and post-checks
   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] op,
                             input int gap_at = -1, input int gap_len = 0);
      logic [31:0] r;
      logic [39:0] fr;
      bit is_ram = 1'b0;
      int starts0;
      case (cmd)
         CMD_ADDR:  begin m_addr = op[12:0]; r = op; end
         CMD_LOAD:  begin m_wdata = op[7:0]; r = op; end
         CMD_WRITE: begin
            is_ram = 1'b1;
            ram_q.push_back('{1'b0, m_addr, m_wdata});
            ref_mem[m_addr] = m_wdata;
            r = 32'd3;
         end
         CMD_READ:  r = {24'd0, m_last_read};
         CMD_READ_REQ: begin
            is_ram = 1'b1;
            ram_q.push_back('{1'b1, m_addr, 8'h00});
            m_last_read = ref_mem[m_addr];
            r = {24'd0, m_last_read};
         end
         CMD_COUNT: begin r = m_count; m_count = m_count + 32'd1; end
         CMD_CONST: r = 32'd259;
         default:   r = 32'hFFFF_FFFF;
      endcase
      for (int i = 0; i < 4; i++) exp_q.push_back(r[31-8*i -: 8]);
      starts0 = n_ram_start;
      fr = {cmd, op};
      for (int i = 0; i < 5; i++) begin
         send_byte(fr[39-8*i -: 8]);
         if (i == gap_at) repeat (gap_len) @(negedge clk);
         else if (i < 4) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle("frame_idle");
      check("resp_bytes_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      check("ram_start_count", 32'(n_ram_start - starts0), is_ram ? 32'd1 : 32'd0);
      check("ram_address", {19'd0, sif.ram_address}, {19'd0, m_addr});
      check("ram_data_write", {24'd0, sif.ram_data_write}, {24'd0, m_wdata});
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish by time limit, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int starts_b;
      int n;
      logic [7:0] v;
      rstn       = 1'b0;
      sif.rcv    = 1'b0;
      sif.rxdata = 8'h00;
      m_addr = 13'd0; m_wdata = 8'd0; m_last_read = 8'd0; m_count = 32'd0;
      for (int i = 0; i < 8192; i++) begin
         v = 8'($urandom);
         ram_mem[i] = v;
         ref_mem[i] = v;
      end
      repeat (3) @(negedge clk);
      check_idle("reset");
      rstn = 1'b1;
      @(negedge clk);

      send_frame(CMD_ADDR, 32'h0000_1234);
      send_frame(CMD_LOAD, 32'h0000_00A5);

      // WRITE with ram_ready held low: no request until it rises
      ram_hold = 1'b1;
      starts_b = n_ram_start;
      fork
         send_frame(CMD_WRITE, 32'h0000_0000);
         begin
            repeat (45) @(negedge clk);
            check("start_while_not_ready", 32'(n_ram_start - starts_b), 32'd0);
            ram_hold = 1'b0;
         end
      join

      send_frame(CMD_ADDR, 32'h0000_0100);
      ram_mem[13'h100] = 8'h5A;
      ref_mem[13'h100] = 8'h5A;
      send_frame(CMD_READ_REQ, 32'h0000_0000);
      send_frame(CMD_READ, 32'h0000_0000);
      repeat (3) send_frame(CMD_COUNT, 32'h0000_0000);
      send_frame(CMD_CONST, 32'h0000_0000);
      send_frame(8'h09, 32'h0000_0000);

      for (int k = 0; k < 40; k++) begin
         int sel;
         logic [7:0] c;
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2, 3, 4, 5, 6: c = 8'(sel + 1);
            7:       c = CMD_READ_REQ;
            8:       c = 8'h00;
            default: c = 8'($urandom_range(8, 255));
         endcase
         send_frame(c, $urandom);
      end

      // Partial frame abandoned past the timeout, then a gap just inside it
      send_byte(CMD_ADDR);
      repeat (2) @(negedge clk);
      send_byte(8'hAA);
      repeat (105) @(negedge clk);
      send_frame(CMD_ADDR, 32'h0000_0007);
      send_frame(CMD_CONST, $urandom, 2, 90);

      // Byte during response transmission is dropped with an overrun pulse
      fork
         send_frame(CMD_CONST, 32'h0000_0000);
         begin
            n = 0;
            while (sif.tx_start !== 1'b1 && n < 500) begin
               @(negedge clk);
               n++;
            end
            check("ovr_tx_started", {31'd0, sif.tx_start}, 32'd1);
            @(negedge clk);
            sif.rcv    = 1'b1;
            sif.rxdata = CMD_COUNT;
            @(negedge clk);
            sif.rcv = 1'b0;
            check("overrun_pulse", {31'd0, sif.overrun}, 32'd1);
            @(negedge clk);
            check("overrun_single", {31'd0, sif.overrun}, 32'd0);
         end
      join
      send_frame(CMD_COUNT, 32'h0000_0000);

      // Reset while the SRAM request is outstanding
      ram_stall = 1'b1;
      ram_q.push_back('{1'b1, m_addr, 8'h00});
      starts_b = n_ram_start;
      for (int i = 0; i < 5; i++) send_byte((i == 0) ? CMD_READ_REQ : 8'h00);
      n = 0;
      while (n_ram_start == starts_b && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rst_req_issued", 32'(n_ram_start - starts_b), 32'd1);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      check_idle("mid_reset");
      m_last_read = ref_mem[m_addr];
      m_addr = 13'd0; m_wdata = 8'd0; m_count = 32'd0;
      ram_stall = 1'b0;
      repeat (10) @(negedge clk);
      send_frame(CMD_COUNT, 32'h0000_0000);
      send_frame(CMD_READ, 32'h0000_0000);

      check("ram_q_left", 32'(ram_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
